// File: rtl/sonic_obstacle_guard_if.sv
// Bus between the range stage / motor controller side and the obstacle guard.
interface sonic_obstacle_guard_if;
  logic        en;
  logic [19:0] distance;
  logic        sample_tick;
  logic [19:0] dist_filt;
  logic [1:0]  state;
  logic        slow;
  logic        stop;
  logic        fault;

  modport master (
    output en, distance,
    input  sample_tick, dist_filt, state, slow, stop, fault
  );

  modport slave (
    input  en, distance,
    output sample_tick, dist_filt, state, slow, stop, fault
  );
endinterface

// File: rtl/sonic_obstacle_guard.sv
// Obstacle guard: periodic range sampling, zero rejection, median-of-3
// filtering and a hysteretic CLEAR/WARN/STOP level that gates the motors.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | path free, full speed
// WARN  | obstacle approaching, motors slowed
// STOP  | obstacle close or sensor faulted, motors stopped (reset state)
module sonic_obstacle_guard #(
  parameter int unsigned SAMPLE_CYCLES = 10_000_000,
  parameter int unsigned STOP_CM       = 15,
  parameter int unsigned WARN_CM       = 30,
  parameter int unsigned HYST_CM       = 5,
  parameter int unsigned CONFIRM       = 3,
  parameter int unsigned ZERO_LIMIT    = 5
) (
  input logic                  clk,
  input logic                  rst,
  sonic_obstacle_guard_if.slave bus
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_WARN  = 2'b01,
    ST_STOP  = 2'b10
  } level_t;

  localparam logic [23:0] TC       = 24'(SAMPLE_CYCLES - 1);
  localparam logic [20:0] STOP_T   = 21'(STOP_CM);
  localparam logic [20:0] WARN_T   = 21'(WARN_CM);
  localparam logic [20:0] STOP_REL = 21'(STOP_CM + HYST_CM);
  localparam logic [20:0] WARN_REL = 21'(WARN_CM + HYST_CM);
  localparam logic [3:0]  CONF_N   = 4'(CONFIRM);
  localparam logic [3:0]  ZLIM     = 4'(ZERO_LIMIT);

  logic [23:0] timer;
  logic        tick;
  logic [19:0] h0, h1, h2;
  logic [1:0]  fill;
  logic [3:0]  zero_cnt;
  logic        cap_eval;
  logic [19:0] filt;
  logic        eval;
  logic        fault;
  logic        fault_next;
  level_t      state_q, state_next;
  logic [3:0]  conf, conf_next;
  logic        slow_q, stop_q;
  logic [20:0] filt_w;

  function automatic logic [19:0] median3(input logic [19:0] a, b, c);
    logic [19:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    median3 = (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  // Sample window timer; only this stage is frozen by en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      tick  <= 1'b0;
    end else if (bus.en) begin
      tick  <= (timer == TC);
      timer <= (timer == TC) ? '0 : timer + 24'd1;
    end else begin
      tick  <= 1'b0;
    end
  end

  // Capture: nonzero readings enter history, zero readings are only counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h0       <= '0;
      h1       <= '0;
      h2       <= '0;
      fill     <= '0;
      zero_cnt <= '0;
      cap_eval <= 1'b0;
    end else begin
      cap_eval <= 1'b0;
      if (tick) begin
        if (bus.distance != 20'd0) begin
          h0       <= bus.distance;
          h1       <= h0;
          h2       <= h1;
          zero_cnt <= '0;
          if (fill != 2'd3) fill <= fill + 2'd1;
          // fill is pre-increment here, so >=2 means history is full after this shift
          cap_eval <= (fill >= 2'd2);
        end else if (zero_cnt != ZLIM) begin
          zero_cnt <= zero_cnt + 4'd1;
        end
      end
    end
  end

  assign fault_next = (zero_cnt == ZLIM);

  // Median filter stage, evaluation strobe and sensor fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt  <= '0;
      eval  <= 1'b0;
      fault <= 1'b0;
    end else begin
      eval  <= cap_eval;
      fault <= fault_next;
      if (cap_eval) filt <= median3(h0, h1, h2);
    end
  end

  assign filt_w = {1'b0, filt};

  // Next level and confirm count: escalate at once, relax one level per CONFIRM evals.
  always_comb begin
    state_next = state_q;
    conf_next  = conf;
    if (fault_next) begin
      state_next = ST_STOP;
      conf_next  = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (eval) begin
            conf_next = '0;
            if (filt_w < STOP_T)      state_next = ST_STOP;
            else if (filt_w < WARN_T) state_next = ST_WARN;
          end
        end
        ST_WARN: begin
          if (eval) begin
            if (filt_w < STOP_T) begin
              state_next = ST_STOP;
              conf_next  = '0;
            end else if (filt_w >= WARN_REL) begin
              if (conf + 4'd1 == CONF_N) begin
                state_next = ST_CLEAR;
                conf_next  = '0;
              end else begin
                conf_next = conf + 4'd1;
              end
            end else begin
              conf_next = '0;
            end
          end
        end
        ST_STOP: begin
          if (eval) begin
            if (filt_w >= STOP_REL) begin
              if (conf + 4'd1 == CONF_N) begin
                state_next = ST_WARN;
                conf_next  = '0;
              end else begin
                conf_next = conf + 4'd1;
              end
            end else begin
              conf_next = '0;
            end
          end
        end
        default: begin
          state_next = ST_STOP;
          conf_next  = '0;
        end
      endcase
    end
  end

  // Level register plus motor gates decoded from the next level so they align with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOP;
      conf    <= '0;
      slow_q  <= 1'b0;
      stop_q  <= 1'b1;
    end else begin
      state_q <= state_next;
      conf    <= conf_next;
      slow_q  <= (state_next == ST_WARN);
      stop_q  <= (state_next == ST_STOP) || fault_next;
    end
  end

  assign bus.sample_tick = tick;
  assign bus.dist_filt   = filt;
  assign bus.state       = state_q;
  assign bus.slow        = slow_q;
  assign bus.stop        = stop_q;
  assign bus.fault       = fault;

endmodule
